// File: rtl/hp_sub_if.sv
// Operand/result handshake bundle for hp_sub; the unit is the slave, the feeder/consumer the master.
interface hp_sub_if #(
    parameter int NEXP = 8,
    parameter int NSIG = 7
);
    localparam int W = NEXP + NSIG + 1;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic [3:0]   flags;
    logic [2:0]   exception;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, s, flags, exception
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, s, flags, exception
    );
endinterface

// File: rtl/hp_sub.sv
// Multi-cycle bfloat16-style subtractor s = a - b, truncating (round toward zero).
// States: IDLE accept pair | ALIGN specials or align | OP add/sub | NORM one shift or pack | DONE hold result
module hp_sub #(
    parameter int NEXP = 8,
    parameter int NSIG = 7
) (
    input  logic    clk,
    input  logic    rst,
    hp_sub_if.slave bus
);
    localparam int W  = NEXP + NSIG + 1;
    localparam int SW = NSIG + 4;
    localparam logic [NEXP-1:0] EXP_ONE = NEXP'(1);
    localparam logic [NEXP-1:0] EXP_MAX = '1;
    localparam logic [NEXP-1:0] EXP_SAT = NEXP'(SW);
    localparam logic [W-1:0]    QNAN    = {1'b0, {NEXP{1'b1}}, 1'b1, {(NSIG-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_OP, S_NORM, S_DONE} state_t;

    state_t          state_q;
    logic [W-1:0]    a_q, b_q;
    logic            in_ready_q, out_valid_q;
    logic [W-1:0]    s_q;
    logic [3:0]      flags_q;
    logic [2:0]      exc_q;
    logic            sign_a_q, sign_b_q, sign_q;
    logic [SW-1:0]   mag_a_q, mag_b_q;
    logic [SW:0]     sig_q;
    logic [NEXP-1:0] exp_q;

    logic            a_sgn, b_sgn;
    logic [NEXP-1:0] a_exp, b_exp;
    logic [NSIG-1:0] a_frc, b_frc;
    logic            a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

    assign {a_sgn, a_exp, a_frc} = a_q;
    assign {b_sgn, b_exp, b_frc} = b_q;

    assign a_nan  = (a_exp == EXP_MAX) && (a_frc != '0);
    assign b_nan  = (b_exp == EXP_MAX) && (b_frc != '0);
    assign a_snan = a_nan && !a_frc[NSIG-1];
    assign b_snan = b_nan && !b_frc[NSIG-1];
    assign a_inf  = (a_exp == EXP_MAX) && (a_frc == '0);
    assign b_inf  = (b_exp == EXP_MAX) && (b_frc == '0);
    assign a_zero = (a_exp == '0) && (a_frc == '0);
    assign b_zero = (b_exp == '0) && (b_frc == '0);

    logic         spc_d;
    logic [W-1:0] spc_s_d;
    logic [3:0]   spc_flags_d;
    logic [2:0]   spc_exc_d;

    always_comb begin
        spc_d       = 1'b1;
        spc_s_d     = QNAN;
        spc_flags_d = 4'b1000;
        spc_exc_d   = 3'b000;
        if (a_nan || b_nan) begin
            spc_exc_d = {a_snan || b_snan, 2'b00};
        end else if (a_inf && b_inf && (a_sgn == b_sgn)) begin
            spc_exc_d = 3'b100;
        end else if (a_inf) begin
            spc_s_d     = {a_sgn, EXP_MAX, {NSIG{1'b0}}};
            spc_flags_d = 4'b0100;
        end else if (b_inf) begin
            spc_s_d     = {~b_sgn, EXP_MAX, {NSIG{1'b0}}};
            spc_flags_d = 4'b0100;
        end else if (a_zero && b_zero) begin
            // only (-0) - (+0) keeps the negative sign
            spc_s_d     = {a_sgn & ~b_sgn, {(W-1){1'b0}}};
            spc_flags_d = 4'b0010;
        end else begin
            spc_d       = 1'b0;
            spc_s_d     = '0;
            spc_flags_d = 4'b0000;
        end
    end

    logic [NEXP-1:0] a_eff, b_eff, exp_diff_d, exp_big_d;
    logic [SW-1:0]   a_sig, b_sig, mag_a_d, mag_b_d;
    logic            a_big;

    always_comb begin
        a_eff      = (a_exp == '0) ? EXP_ONE : a_exp;
        b_eff      = (b_exp == '0) ? EXP_ONE : b_exp;
        a_sig      = {(a_exp != '0), a_frc, 3'b000};
        b_sig      = {(b_exp != '0), b_frc, 3'b000};
        a_big      = (a_eff >= b_eff);
        exp_diff_d = a_big ? (a_eff - b_eff) : (b_eff - a_eff);
        exp_big_d  = a_big ? a_eff : b_eff;
        mag_a_d    = a_sig;
        mag_b_d    = b_sig;
        if (a_big) begin
            mag_b_d = (exp_diff_d >= EXP_SAT) ? '0 : (b_sig >> exp_diff_d);
        end else begin
            mag_a_d = (exp_diff_d >= EXP_SAT) ? '0 : (a_sig >> exp_diff_d);
        end
    end

    logic [SW:0] op_sum_d;
    logic        op_sign_d;

    always_comb begin
        op_sum_d  = '0;
        op_sign_d = sign_a_q;
        if (sign_a_q == sign_b_q) begin
            op_sum_d = {1'b0, mag_a_q} + {1'b0, mag_b_q};
        end else if (mag_a_q >= mag_b_q) begin
            op_sum_d = {1'b0, mag_a_q - mag_b_q};
        end else begin
            op_sum_d  = {1'b0, mag_b_q - mag_a_q};
            op_sign_d = sign_b_q;
        end
    end

    logic [W-1:0] pk_s_d;
    logic [3:0]   pk_flags_d;
    logic [2:0]   pk_exc_d;

    always_comb begin
        pk_s_d     = {sign_q, exp_q, sig_q[SW-2 -: NSIG]};
        pk_flags_d = 4'b0000;
        pk_exc_d   = 3'b000;
        if (exp_q == EXP_MAX) begin
            pk_s_d     = {sign_q, EXP_MAX, {NSIG{1'b0}}};
            pk_flags_d = 4'b0100;
            pk_exc_d   = 3'b010;
        end else if (!sig_q[SW-1]) begin
            pk_s_d     = {sign_q, {NEXP{1'b0}}, sig_q[SW-2 -: NSIG]};
            pk_flags_d = 4'b0001;
            pk_exc_d   = 3'b001;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            flags_q     <= '0;
            exc_q       <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            sign_q      <= 1'b0;
            mag_a_q     <= '0;
            mag_b_q     <= '0;
            sig_q       <= '0;
            exp_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        in_ready_q <= 1'b0;
                        state_q    <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    if (spc_d) begin
                        s_q         <= spc_s_d;
                        flags_q     <= spc_flags_d;
                        exc_q       <= spc_exc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        sign_a_q <= a_sgn;
                        sign_b_q <= ~b_sgn;
                        mag_a_q  <= mag_a_d;
                        mag_b_q  <= mag_b_d;
                        exp_q    <= exp_big_d;
                        state_q  <= S_OP;
                    end
                end
                S_OP: begin
                    if (op_sum_d == '0) begin
                        s_q         <= '0;
                        flags_q     <= 4'b0010;
                        exc_q       <= 3'b000;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        sig_q   <= op_sum_d;
                        sign_q  <= op_sign_d;
                        state_q <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (sig_q[SW]) begin
                        sig_q <= sig_q >> 1;
                        exp_q <= exp_q + EXP_ONE;
                    end else if (!sig_q[SW-1] && (exp_q > EXP_ONE)) begin
                        sig_q <= sig_q << 1;
                        exp_q <= exp_q - EXP_ONE;
                    end else begin
                        s_q         <= pk_s_d;
                        flags_q     <= pk_flags_d;
                        exc_q       <= pk_exc_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.flags     = flags_q;
    assign bus.exception = exc_q;
endmodule

// File: tb/tb_hp_sub.sv
// Bench for hp_sub: directed corner cases plus randomized operands against a value-level reference.
module tb_hp_sub;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    logic [15:0] spc_tbl [8] = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80,
                                 16'h7FC0, 16'h7F81, 16'hFFA0, 16'h0001};

    always #5 clk = ~clk;

    hp_sub_if #(.NEXP(8), .NSIG(7)) bus ();
    hp_sub #(.NEXP(8), .NSIG(7)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Reference: operands as signed scaled integers, exact difference, then normalize/truncate.
    task automatic ref_sub(input logic [15:0] a, input logic [15:0] b,
                           output logic [15:0] s, output logic [3:0] f,
                           output logic [2:0] e, output int lat);
        int ea, eb, fa, fb, xa, xb, ma, mb, d, r, mag, x, shifts;
        bit sa, sb, na, nb, ia, ib, za, zb, neg;
        sa = a[15]; ea = int'(a[14:7]); fa = int'(a[6:0]);
        sb = b[15]; eb = int'(b[14:7]); fb = int'(b[6:0]);
        na = (ea == 255) && (fa != 0); nb = (eb == 255) && (fb != 0);
        ia = (ea == 255) && (fa == 0); ib = (eb == 255) && (fb == 0);
        za = (ea == 0) && (fa == 0);   zb = (eb == 0) && (fb == 0);
        s = 16'h0000; f = 4'b0000; e = 3'b000; lat = 1;
        if (na || nb) begin
            s = 16'h7FC0; f = 4'b1000;
            if ((na && fa < 64) || (nb && fb < 64)) e = 3'b100;
        end else if (ia && ib && sa == sb) begin
            s = 16'h7FC0; f = 4'b1000; e = 3'b100;
        end else if (ia) begin
            s = {sa, 8'hFF, 7'h00}; f = 4'b0100;
        end else if (ib) begin
            s = {~sb, 8'hFF, 7'h00}; f = 4'b0100;
        end else if (za && zb) begin
            s = (sa && !sb) ? 16'h8000 : 16'h0000; f = 4'b0010;
        end else begin
            xa = (ea == 0) ? 1 : ea;
            xb = (eb == 0) ? 1 : eb;
            ma = ((ea != 0) ? 1024 : 0) + fa * 8;
            mb = ((eb != 0) ? 1024 : 0) + fb * 8;
            if (xa >= xb) begin
                d = xa - xb; mb = (d >= 11) ? 0 : (mb >> d); x = xa;
            end else begin
                d = xb - xa; ma = (d >= 11) ? 0 : (ma >> d); x = xb;
            end
            r = (sa ? -ma : ma) - (sb ? -mb : mb);
            if (r == 0) begin
                f = 4'b0010; lat = 2;
            end else begin
                neg = (r < 0);
                mag = neg ? -r : r;
                shifts = 0;
                if (mag >= 2048) begin
                    mag = mag / 2; x++; shifts = 1;
                end else begin
                    while (mag < 1024 && x > 1) begin
                        mag = mag * 2; x--; shifts++;
                    end
                end
                lat = 3 + shifts;
                if (x >= 255) begin
                    s = {neg, 8'hFF, 7'h00}; f = 4'b0100; e = 3'b010;
                end else if (mag < 1024) begin
                    s = {neg, 8'h00, 7'(mag / 8)}; f = 4'b0001; e = 3'b001;
                end else begin
                    s = {neg, 8'(x), 7'(mag / 8)};
                end
            end
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] es, input logic [3:0] ef, input logic [2:0] ee,
                          input int elat, input int hold, input string tag);
        int n;
        int lat;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        bus.a = a; bus.b = b; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        chk({tag, "_lat"},   32'(lat),           32'(elat));
        chk({tag, "_s"},     32'(bus.s),         32'(es));
        chk({tag, "_flags"}, 32'(bus.flags),     32'(ef));
        chk({tag, "_exc"},   32'(bus.exception), 32'(ee));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_s"},  32'(bus.s),         32'(es));
            chk({tag, "_hold_ov"}, 32'(bus.out_valid), 32'd1);
            chk({tag, "_hold_ir"}, 32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        if (hold > 0) bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk({tag, "_rel_ov"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rel_ir"}, 32'(bus.in_ready),  32'd1);
        chk({tag, "_rel_s"},  32'(bus.s),         32'(es));
        bus.in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] ra, rb, es;
        logic [3:0]  ef;
        logic [2:0]  ee;
        int          el, cat, ea, eb;

        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_s",         32'(bus.s),         32'd0);
        chk("rst_flags",     32'(bus.flags),     32'd0);
        chk("rst_exc",       32'(bus.exception), 32'd0);

        run_op(16'h3F80, 16'h3F00, 16'h3F00, 4'b0000, 3'b000, 4, 0, "half");
        run_op(16'h3F80, 16'hBF80, 16'h4000, 4'b0000, 3'b000, 4, 0, "carry");
        run_op(16'h3F80, 16'h3F80, 16'h0000, 4'b0010, 3'b000, 2, 0, "zero_diff");
        run_op(16'h7F80, 16'h7F80, 16'h7FC0, 4'b1000, 3'b100, 1, 0, "inf_inf");
        run_op(16'h7F81, 16'h3F80, 16'h7FC0, 4'b1000, 3'b100, 1, 0, "snan");
        run_op(16'h7FC0, 16'h3F80, 16'h7FC0, 4'b1000, 3'b000, 1, 0, "qnan");
        run_op(16'h0080, 16'h0040, 16'h0040, 4'b0001, 3'b001, 3, 0, "subnorm");
        run_op(16'h7F7F, 16'hFF7F, 16'h7F80, 4'b0100, 3'b010, 4, 0, "overflow");
        run_op(16'h8000, 16'h0000, 16'h8000, 4'b0010, 3'b000, 1, 0, "negzero");
        run_op(16'h0000, 16'h8000, 16'h0000, 4'b0010, 3'b000, 1, 0, "poszero");
        run_op(16'h3F80, 16'h7F80, 16'hFF80, 4'b0100, 3'b000, 1, 0, "minus_inf");
        run_op(16'hFF80, 16'hFF80, 16'h7FC0, 4'b1000, 3'b100, 1, 0, "ninf_ninf");
        run_op(16'h3F80, 16'h3F00, 16'h3F00, 4'b0000, 3'b000, 4, 5, "hold5");

        bus.a = 16'h3F80; bus.b = 16'h3C00; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("norm_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_s",         32'(bus.s),         32'd0);
        chk("mid_rst_flags",     32'(bus.flags),     32'd0);
        chk("mid_rst_exc",       32'(bus.exception), 32'd0);
        run_op(16'h3F80, 16'h3F00, 16'h3F00, 4'b0000, 3'b000, 4, 0, "after_rst");

        for (int i = 0; i < 400; i++) begin
            cat = int'($urandom_range(0, 5));
            ra = 16'($urandom);
            rb = 16'($urandom);
            case (cat)
                1: begin
                    ea = int'($urandom_range(1, 254));
                    eb = ea + int'($urandom_range(0, 6)) - 3;
                    if (eb < 0) eb = 0;
                    if (eb > 254) eb = 254;
                    ra[14:7] = 8'(ea);
                    rb[14:7] = 8'(eb);
                end
                2: begin
                    ra[14:7] = 8'($urandom_range(0, 3));
                    rb[14:7] = 8'($urandom_range(0, 3));
                end
                3: begin
                    ra[14:7] = 8'($urandom_range(250, 254));
                    rb[14:7] = 8'($urandom_range(250, 254));
                end
                4: begin
                    ra = spc_tbl[$urandom_range(0, 7)];
                    if ($urandom_range(0, 1) == 1) rb = spc_tbl[$urandom_range(0, 7)];
                end
                5: begin
                    if (ra[14:7] == 8'hFF) ra[14:7] = 8'h80;
                    rb = {ra[15:3], 3'($urandom)};
                end
                default: ;
            endcase
            ref_sub(ra, rb, es, ef, ee, el);
            run_op(ra, rb, es, ef, ee, el, 0, $sformatf("rnd%0d_%h_%h", i, ra, rb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached checks=%0d", n_chk);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/hp_sub.md
HP_SUB -- requirements
Module: hp_sub

Interface
REQ-001 Parameter NEXP, default 8: exponent field width.
REQ-002 Parameter NSIG, default 7: stored fraction width; word width W = NEXP+NSIG+1.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  operand pair a, b present.
REQ-006 in_ready  out  1  unit can accept an operand pair.
REQ-007 a  in  W  minuend, bfloat16 layout {sign, exp, frac}.
REQ-008 b  in  W  subtrahend, same layout.
REQ-009 out_valid  out  1  result s, flags and exception are valid.
REQ-010 out_ready  in  1  consumer accepts the result.
REQ-011 s  out  W  result of a - b.
REQ-012 flags  out  4  result class {nan, inf, zero, subnormal}, MSB first.
REQ-013 exception  out  3  {invalid, overflow, underflow}, MSB first.

Function
REQ-014 The unit SHALL handle one operation at a time, with states IDLE, ALIGN, OP, NORM and DONE.
REQ-015 IDLE: in_ready=1; when in_valid=1, a and b SHALL be latched and the state SHALL become ALIGN; in_ready=0 in every other state.
REQ-016 ALIGN, special operands, next state DONE:
  - any NaN -> s=0x7FC0, flags.nan; exception.invalid if either operand is a signalling NaN (exp all-ones, frac!=0, frac MSB=0).
  - inf - inf of equal sign -> 0x7FC0 with invalid.
  - any other inf -> signed inf, flags.inf.
  - both zero -> -0 only for (-0)-(+0), else +0; flags.zero.
REQ-017 ALIGN, all other operands: effective b sign = ~b.sign; exp 0 means hidden bit 0 and effective exponent 1; build 11-bit significands {hidden, frac, 3 guard zeros}; right-shift the smaller-exponent operand by the exponent difference, saturating to 0 at a difference of 11 or more; larger exponent becomes the working exponent; next state OP.
REQ-018 OP, equal effective signs: add magnitudes into a 12-bit sum.
REQ-019 OP, unequal effective signs: subtract the smaller from the larger magnitude; sign = that of the larger-magnitude operand.
REQ-020 OP: a zero difference SHALL give s=+0 with flags.zero, next DONE; otherwise next NORM.
REQ-021 NORM, one action per cycle:
  - carry set -> right-shift 1, exponent+1;
  - else MSB=0 and exponent>1 -> left-shift 1, exponent-1;
  - else pack the result and go to DONE.
REQ-022 Packing:
  - truncate the guard bits (round toward zero);
  - MSB=0 at exponent 1 -> encoded exp 0, flags.subnormal, exception.underflow;
  - exponent reaching 2^NEXP-1 -> signed inf, flags.inf, exception.overflow.
REQ-023 Latency from the accepting edge to out_valid high SHALL be 1 cycle for specials, 2 for a zero difference, and 3 plus the NORM shift count otherwise.
REQ-024 DONE: out_valid=1 with s, flags and exception held stable until out_ready=1; that edge SHALL return to IDLE; no new operand pair is accepted in the same cycle.
REQ-025 s, flags and exception SHALL change only on entry to DONE.

Reset
REQ-026 rst=1 at an edge SHALL, in any state including mid-operation, force IDLE, out_valid=0, s=0, flags=0, exception=0 and discard the operation in flight; in_ready is 1 on the first cycle after reset.

Verification
REQ-027 a=0x3F80, b=0x3F00 -> s=0x3F00, flags=0, exception=0, latency 4.
REQ-028 a=0x3F80, b=0xBF80 -> s=0x4000 (carry path), latency 4; a=0x3F80, b=0x3F80 -> s=0x0000, flags.zero, latency 2.
REQ-029 a=0x7F80, b=0x7F80 -> s=0x7FC0, flags.nan, exception.invalid, latency 1; a=0x7F81, b=0x3F80 -> s=0x7FC0, invalid.
REQ-030 a=0x0080, b=0x0040 -> s=0x0040, flags.subnormal, exception.underflow, latency 3.
REQ-031 Hold out_ready=0 for 5 cycles in DONE -> s stable, out_valid=1, in_ready=0 throughout; raising out_ready -> IDLE on the next edge.
REQ-032 Assert rst during NORM of 0x3F80-0x3C00 -> all outputs zero next cycle, in_ready=1; a new 0x3F80-0x3F00 -> 0x3F00.
